// File: rtl/axis_traffic_gen.sv
// AXI-Stream NoC traffic endpoint: bursts of multi-flit packets (LFSR or counter payload)
// over a round-robin destination set, plus a statistics sink. Optional TRAFFIC_GEN_STATS_EN adds a stall counter.
module axis_traffic_gen #(
  parameter int                 TDATAW       = 32,
  parameter int                 TDESTW       = 4,
  parameter int                 LFSR_DW      = 8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = LFSR_DW'(8'h01),
  parameter logic [LFSR_DW-1:0] LFSR_TAPS    = LFSR_DW'(8'hB8),
  parameter int                 NUM_PACKETS  = 4,
  parameter int                 MAX_LEN      = 8,
  parameter int                 NUM_DEST     = 2,
  parameter int                 DEST_BASE    = 1,
  parameter int                 GAP_CYCLES   = 0,
  localparam int                LENW         = $clog2(MAX_LEN+1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              MODE,
  input  logic [LENW-1:0]   PKT_LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [15:0]       RX_PKTS,
  output logic [TDATAW-1:0] RX_CHECKSUM,
  output logic [31:0]       STALL_CYCLES
);

  localparam int DIW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_e;

  state_e             state_q, state_d;
  logic [LENW-1:0]    len_q, len_d, len_clamp;
  logic               mode_q, mode_d;
  logic [15:0]        flit_q, flit_d;
  logic [15:0]        pkt_q, pkt_d;
  logic [DIW-1:0]     dest_q, dest_d;
  logic [15:0]        gap_q, gap_d;
  logic [LFSR_DW-1:0] lfsr_q, lfsr_d, lfsr_shift, lfsr_nxt;
  logic               m_hs, last_flit, last_pkt;

  always_comb begin
    len_clamp = PKT_LEN;
    if (PKT_LEN == '0)                    len_clamp = LENW'(1);
    else if (PKT_LEN > LENW'(MAX_LEN))    len_clamp = LENW'(MAX_LEN);
  end

  // Galois step; a zero state would lock up, so it falls back to the seed
  assign lfsr_shift = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign lfsr_nxt   = (lfsr_shift == '0) ? LFSR_DEFAULT : lfsr_shift;

  assign m_hs      = (state_q == SEND) & AXIS_M_TREADY;
  assign last_flit = (flit_q == 16'(len_q) - 16'd1);
  assign last_pkt  = (pkt_q == 16'(NUM_PACKETS - 1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    flit_d  = flit_q;
    pkt_d   = pkt_q;
    dest_d  = dest_q;
    gap_d   = gap_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = SEND;
        len_d   = len_clamp;
        mode_d  = MODE;
        flit_d  = '0;
        pkt_d   = '0;
        dest_d  = '0;
      end
      SEND: if (m_hs) begin
        if (!mode_q) lfsr_d = lfsr_nxt;
        if (last_flit) begin
          flit_d = '0;
          pkt_d  = pkt_q + 16'd1;
          dest_d = (dest_q == DIW'(NUM_DEST - 1)) ? '0 : dest_q + DIW'(1);
          if (last_pkt) state_d = FINISH;
          else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          flit_d = flit_q + 16'd1;
        end
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == 16'(GAP_CYCLES - 1)) state_d = SEND;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      mode_q  <= 1'b0;
      flit_q  <= '0;
      pkt_q   <= '0;
      dest_q  <= '0;
      gap_q   <= '0;
      lfsr_q  <= LFSR_DEFAULT;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      flit_q  <= flit_d;
      pkt_q   <= pkt_d;
      dest_q  <= dest_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Payload/sideband forced to zero outside SEND so idle outputs read as 0
  assign AXIS_M_TVALID = (state_q == SEND);
  assign AXIS_M_TLAST  = AXIS_M_TVALID & last_flit;
  assign AXIS_M_TDATA  = !AXIS_M_TVALID ? '0 :
                         mode_q ? TDATAW'({pkt_q, flit_q}) : TDATAW'(lfsr_q);
  assign AXIS_M_TDEST  = AXIS_M_TVALID ? TDESTW'(DEST_BASE) + TDESTW'(dest_q) : '0;
  assign BUSY          = (state_q != IDLE);
  assign DONE          = (state_q == FINISH);

  logic              s_rdy_q;
  logic [15:0]       rx_pkts_q;
  logic [TDATAW-1:0] rx_sum_q;
  logic              s_hs;
  logic              unused_s_tdest;

  assign s_hs           = AXIS_S_TVALID & s_rdy_q;
  assign unused_s_tdest = ^AXIS_S_TDEST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_rdy_q   <= 1'b0;
      rx_pkts_q <= '0;
      rx_sum_q  <= '0;
    end else begin
      s_rdy_q <= 1'b1;
      if (s_hs) begin
        rx_sum_q <= rx_sum_q ^ AXIS_S_TDATA;
        if (AXIS_S_TLAST) rx_pkts_q <= rx_pkts_q + 16'd1;
      end
    end
  end

  assign AXIS_S_TREADY = s_rdy_q;
  assign RX_PKTS       = rx_pkts_q;
  assign RX_CHECKSUM   = rx_sum_q;

`ifdef TRAFFIC_GEN_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_q <= '0;
    else if (AXIS_M_TVALID && !AXIS_M_TREADY && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign STALL_CYCLES = stall_q;
`else
  assign STALL_CYCLES = '0;
`endif

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: two instances (2 pkts/no gap, 4 pkts/gap 2).
module tb_axis_traffic_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_start, a_mode, a_busy, a_done, a_mv, a_mr, a_ml, a_sv, a_sr, a_sl;
  logic [3:0]  a_len, a_mdst, a_sdst;
  logic [31:0] a_md, a_sd, a_rxs, a_stall;
  logic [15:0] a_rxp;

  logic        b_start, b_mode, b_busy, b_done, b_mv, b_mr, b_ml, b_sv, b_sr, b_sl;
  logic [3:0]  b_len, b_mdst, b_sdst;
  logic [31:0] b_md, b_sd, b_rxs, b_stall;
  logic [15:0] b_rxp;

  axis_traffic_gen #(.NUM_PACKETS(2), .NUM_DEST(2), .GAP_CYCLES(0)) u_a (
    .CLK(clk), .RST(rst), .START(a_start), .MODE(a_mode), .PKT_LEN(a_len),
    .BUSY(a_busy), .DONE(a_done),
    .AXIS_M_TVALID(a_mv), .AXIS_M_TREADY(a_mr), .AXIS_M_TDATA(a_md),
    .AXIS_M_TLAST(a_ml), .AXIS_M_TDEST(a_mdst),
    .AXIS_S_TVALID(a_sv), .AXIS_S_TREADY(a_sr), .AXIS_S_TDATA(a_sd),
    .AXIS_S_TLAST(a_sl), .AXIS_S_TDEST(a_sdst),
    .RX_PKTS(a_rxp), .RX_CHECKSUM(a_rxs), .STALL_CYCLES(a_stall));

  axis_traffic_gen #(.NUM_PACKETS(4), .NUM_DEST(2), .GAP_CYCLES(2)) u_b (
    .CLK(clk), .RST(rst), .START(b_start), .MODE(b_mode), .PKT_LEN(b_len),
    .BUSY(b_busy), .DONE(b_done),
    .AXIS_M_TVALID(b_mv), .AXIS_M_TREADY(b_mr), .AXIS_M_TDATA(b_md),
    .AXIS_M_TLAST(b_ml), .AXIS_M_TDEST(b_mdst),
    .AXIS_S_TVALID(b_sv), .AXIS_S_TREADY(b_sr), .AXIS_S_TDATA(b_sd),
    .AXIS_S_TLAST(b_sl), .AXIS_S_TDEST(b_sdst),
    .RX_PKTS(b_rxp), .RX_CHECKSUM(b_rxs), .STALL_CYCLES(b_stall));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] v);
    logic [7:0] s;
    s = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    if (s == 8'h00) s = 8'h01;
    return s;
  endfunction

  // flit capture and stall/stability observation, sampled mid-cycle
  logic [31:0] qa_d[$], qb_d[$];
  logic        qa_l[$], qb_l[$];
  logic [3:0]  qa_t[$], qb_t[$];
  int          qa_c[$], qb_c[$];
  int          a_done_c = 0, b_done_c = 0, a_stall_n = 0, a_stab_err = 0;
  logic        pa_v = 1'b0, pa_r = 1'b0, pa_l = 1'b0;
  logic [31:0] pa_d = '0;
  logic [3:0]  pa_t = '0;

  always @(negedge clk) begin
    if (rst) begin
      a_stall_n = 0;
      pa_v = 1'b0;
    end else begin
      if (a_mv && a_mr) begin
        qa_d.push_back(a_md); qa_l.push_back(a_ml); qa_t.push_back(a_mdst); qa_c.push_back(cyc);
      end
      if (a_mv && !a_mr) a_stall_n++;
      if (pa_v && !pa_r && (!a_mv || a_md !== pa_d || a_ml !== pa_l || a_mdst !== pa_t))
        a_stab_err++;
      pa_v = a_mv; pa_r = a_mr; pa_d = a_md; pa_l = a_ml; pa_t = a_mdst;
      if (a_done) a_done_c = cyc;
      if (b_mv && b_mr) begin
        qb_d.push_back(b_md); qb_l.push_back(b_ml); qb_t.push_back(b_mdst); qb_c.push_back(cyc);
      end
      if (b_done) b_done_c = cyc;
    end
  end

  task automatic clr_a();
    qa_d.delete(); qa_l.delete(); qa_t.delete(); qa_c.delete();
  endtask

  task automatic wait_a(input int max);
    int n = 0;
    while (!a_done && n < max) begin tick(); n++; end
    if (!a_done) chk("a_done_timeout", 32'd0, 32'd1);
    else         chk("a_busy_with_done", 32'(a_busy), 32'd1);
  endtask

  logic [7:0]  m_lfsr;
  logic [31:0] exp1 [6];

  initial begin
    exp1 = '{32'h01, 32'hB8, 32'h5C, 32'h2E, 32'h17, 32'hB3};
    rst = 1'b1;
    a_start = 0; a_mode = 0; a_len = 0; a_mr = 1; a_sv = 0; a_sd = 0; a_sl = 0; a_sdst = 0;
    b_start = 0; b_mode = 0; b_len = 0; b_mr = 1; b_sv = 0; b_sd = 0; b_sl = 0; b_sdst = 0;
    repeat (2) tick();
    // reset state
    chk("rst_tvalid", 32'(a_mv), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_tdata", a_md, 0);
    chk("rst_tlast", 32'(a_ml), 0);
    chk("rst_tdest", 32'(a_mdst), 0);
    chk("rst_s_tready", 32'(a_sr), 0);
    chk("rst_rx_pkts", 32'(a_rxp), 0);
    chk("rst_rx_sum", a_rxs, 0);
    chk("rst_stall", a_stall, 0);
    rst = 1'b0;
    tick();
    chk("s_tready_up", 32'(a_sr), 1);
    m_lfsr = 8'h01;

    // burst 1: 2 x 3 flits, LFSR payload
    a_len = 3; a_mode = 0; a_start = 1;
    tick();
    chk("start_tvalid", 32'(a_mv), 1);
    chk("start_busy", 32'(a_busy), 1);
    a_start = 0;
    wait_a(50);
    tick();
    chk("t1_count", qa_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_data%0d", i), qa_d[i], exp1[i]);
      chk($sformatf("t1_last%0d", i), 32'(qa_l[i]), (i % 3 == 2) ? 1 : 0);
      chk($sformatf("t1_dest%0d", i), 32'(qa_t[i]), 1 + i / 3);
      chk($sformatf("t1_cyc%0d", i), qa_c[i], qa_c[0] + i);
      m_lfsr = lstep(m_lfsr);
    end
    chk("t1_done_cyc", a_done_c, qa_c[5] + 1);
    chk("t1_done_pulse", 32'(a_done), 0);

    // instance B: counter payload, 4 x 2 flits, gap 2
    b_len = 2; b_mode = 1; b_start = 1;
    tick();
    b_start = 0;
    for (int n = 0; n < 80 && !b_done; n++) tick();
    chk("b_done_seen", 32'(b_done), 1);
    tick();
    chk("t2_count", qb_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_data%0d", i), qb_d[i], ((i / 2) << 16) | (i % 2));
      chk($sformatf("t2_dest%0d", i), 32'(qb_t[i]), 1 + (i / 2) % 2);
      chk($sformatf("t2_last%0d", i), 32'(qb_l[i]), i % 2);
      if (i > 0) chk($sformatf("t2_spacing%0d", i), qb_c[i] - qb_c[i-1], (i % 2 == 0) ? 3 : 1);
    end
    chk("t2_pkt2_flit1", qb_d[5], 32'h0002_0001);
    chk("t2_done_cyc", b_done_c, qb_c[7] + 1);

    // random backpressure, PKT_LEN 15 clamps to 8
    clr_a();
    a_len = 15; a_mode = 0; a_start = 1;
    tick();
    a_start = 0;
    for (int n = 0; n < 400 && !a_done; n++) begin
      a_mr = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t3_done_seen", 32'(a_done), 1);
    a_mr = 1;
    tick();
    chk("t3_count", qa_d.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_data%0d", i), qa_d[i], 32'(m_lfsr));
      chk($sformatf("t3_last%0d", i), 32'(qa_l[i]), (i % 8 == 7) ? 1 : 0);
      chk($sformatf("t3_dest%0d", i), 32'(qa_t[i]), 1 + i / 8);
      m_lfsr = lstep(m_lfsr);
    end
    chk("t3_stable", a_stab_err, 0);
`ifdef TRAFFIC_GEN_STATS_EN
    chk("t3_stall_cycles", a_stall, a_stall_n);
`else
    chk("t3_stall_cycles", a_stall, 0);
`endif

    // PKT_LEN 0 -> 1-flit packets; START held through FINISH is ignored there
    clr_a();
    a_len = 0; a_start = 1;
    tick();
    wait_a(50);
    tick();
    chk("t4_finish_ignores_start", 32'(a_busy), 0);
    tick();
    chk("t4_restart_tvalid", 32'(a_mv), 1);
    a_start = 0;
    wait_a(50);
    tick();
    chk("t4_count", qa_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), qa_d[i], 32'(m_lfsr));
      chk($sformatf("t4_last%0d", i), 32'(qa_l[i]), 1);
      chk($sformatf("t4_dest%0d", i), 32'(qa_t[i]), 1 + i % 2);
      m_lfsr = lstep(m_lfsr);
    end

    // reset mid-packet
    a_len = 8; a_start = 1;
    tick();
    a_start = 0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_tvalid_async", 32'(a_mv), 0);
    chk("t5_busy_async", 32'(a_busy), 0);
    tick();
    rst = 1'b0;
    clr_a();
    tick();
    a_len = 1; a_start = 1;
    tick();
    a_start = 0;
    wait_a(50);
    tick();
    chk("t5_count", qa_d.size(), 2);
    chk("t5_reseed0", qa_d[0], 32'h01);
    chk("t5_reseed1", qa_d[1], 32'hB8);

    // slave: packets {5,3} {F} {1}
    a_sv = 1; a_sd = 32'h5; a_sl = 0; tick();
    a_sd = 32'h3; a_sl = 1; tick();
    a_sv = 0; a_sd = 32'hFF; tick();
    a_sv = 1; a_sd = 32'hF; a_sl = 1; a_sdst = 4'h7; tick();
    a_sd = 32'h1; tick();
    a_sv = 0; a_sl = 0; tick();
    chk("rx_pkts", 32'(a_rxp), 3);
    chk("rx_checksum", a_rxs, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
# axis_traffic_gen

Parametrised AXI-Stream traffic endpoint for the mesh NoC. It supersedes the fixed single-destination number generator. It injects NUM_PACKETS multi-flit packets per START, spreading them round-robin over NUM_DEST consecutive router destinations, with LFSR or counter payloads. On its slave side it sinks returning traffic and keeps packet, checksum and optional stall statistics. One instance attaches to each router user port, both master and slave.

## Interface
Parameters:
- TDATAW, 32, flit data width (≥ 32)
- TDESTW, 4, destination field width
- LFSR_DW, 8, LFSR width (≤ TDATAW)
- LFSR_DEFAULT, 8'h01, LFSR reset/reseed value (nonzero)
- LFSR_TAPS, 8'hB8, Galois tap mask
- NUM_PACKETS, 4, packets per START (≥ 1)
- MAX_LEN, 8, maximum flits per packet
- NUM_DEST, 2, destinations in rotation (≥ 1)
- DEST_BASE, 1, first destination
- GAP_CYCLES, 0, idle cycles between packets

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- START  in  1  begin a burst (sampled in IDLE only)
- MODE  in  1  payload: 0 = LFSR, 1 = counter
- PKT_LEN  in  $clog2(MAX_LEN+1)  flits per packet, sampled with START
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse at burst end
- AXIS_M_TVALID/TREADY/TDATA/TLAST/TDEST  out/in/out/out/out  1/1/TDATAW/1/TDESTW  injection stream
- AXIS_S_TVALID/TREADY/TDATA/TLAST/TDEST  in/out/in/in/in  1/1/TDATAW/1/TDESTW  ejection stream
- RX_PKTS  out  16  received packet count
- RX_CHECKSUM  out  TDATAW  XOR of all received flits
- STALL_CYCLES  out  32  master backpressure cycles

## Operation
- FSM states: IDLE, SEND, GAP, FINISH.
- IDLE → SEND when START = 1. START in any other state is ignored.
- On entry to SEND, latch len = PKT_LEN. A value of 0 becomes 1; values > MAX_LEN clamp to MAX_LEN. Also latch MODE.
- SEND presents one flit with TVALID = 1. The flit advances only on TVALID & TREADY.
- TLAST = 1 on flit len-1.
- After the last flit of a packet:
  - FINISH if pkt_idx == NUM_PACKETS-1.
  - Otherwise GAP if GAP_CYCLES > 0, else straight back to SEND.
- GAP counts GAP_CYCLES cycles, then returns to SEND.
- FINISH lasts one cycle with DONE = 1, then goes to IDLE.
- TDEST = DEST_BASE + dest_idx. dest_idx starts at 0 every burst and increments per packet, wrapping NUM_DEST-1 → 0.
- Payload, MODE = 0: zero-extended LFSR value.
  - On each accepted flit: lfsr = lsb ? (lfsr>>1) ^ LFSR_TAPS : lfsr>>1.
  - If the LFSR ever reads 0, it reloads LFSR_DEFAULT.
  - The LFSR persists across bursts; only RST reseeds it.
- Payload, MODE = 1: {pkt_idx[15:0], flit_idx[15:0]}, upper bits zero.
- Slave side: AXIS_S_TREADY = 1 whenever not in reset.
  - On every S handshake: RX_CHECKSUM ^= TDATA.
  - RX_PKTS increments when TLAST is also set; it wraps 0xFFFF → 0.
  - Slave TDEST is ignored.

## Timing
- Reset values: all outputs 0, including AXIS_S_TREADY, BUSY and DONE. LFSR = LFSR_DEFAULT, FSM = IDLE.
- START high at edge N: TVALID and BUSY high from edge N+1.
- With TREADY held high, one flit per cycle and no bubbles inside a packet.
  - Packets are back-to-back when GAP_CYCLES = 0.
  - Otherwise exactly GAP_CYCLES bubbles between packets.
- TDATA, TLAST and TDEST are stable while TVALID = 1 and TREADY = 0. TVALID never drops before the handshake.
- DONE is asserted in the cycle after the final handshake. BUSY = (state ≠ IDLE), so BUSY is still high while DONE is high.
- Reset asserted mid-burst clears all state asynchronously, with TVALID low immediately. The partial packet is abandoned.
- START asserted during FINISH is ignored. START in the IDLE cycle right after FINISH begins a new burst.

## Configuration
- TRAFFIC_GEN_STATS_EN defined: STALL_CYCLES increments every cycle with AXIS_M_TVALID & !AXIS_M_TREADY. It saturates at 0xFFFFFFFF and clears only on RST.
- Not defined: STALL_CYCLES is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset, then START with NUM_PACKETS = 2, PKT_LEN = 3, MODE = 0, TREADY = 1:
  - 6 flits with TDATA 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
  - TLAST on flits 3 and 6; TDEST 1 then 2.
  - DONE pulses one cycle after flit 6.
- MODE = 1, NUM_DEST = 2, NUM_PACKETS = 4, PKT_LEN = 2:
  - TDEST 1, 2, 1, 2.
  - Packet 2 flit 1 TDATA = 0x00020001.
- TREADY toggled randomly: no flit lost or duplicated, payload stable while stalled. With TRAFFIC_GEN_STATS_EN, STALL_CYCLES equals the stalled-cycle count.
- PKT_LEN = 0 yields 1-flit packets; PKT_LEN = 15 with MAX_LEN = 8 yields 8-flit packets. GAP_CYCLES = 2 yields exactly 2 idle cycles between packets.
- RST asserted mid-packet: TVALID falls at once. A new START produces a first flit of 0x01 (LFSR reseeded).
- Slave receives 3 packets of data 0x5, 0x3 | 0xF | 0x1: RX_PKTS = 3, RX_CHECKSUM = 0x8.
